// File: rtl/pulse_pkg.sv
// Shared constants for the pulse generator chain: stream opcodes, default
// geometry and the packed edge record layout.
package pulse_pkg;

  localparam logic [7:0] OP_PERIOD = 8'h01;
  localparam logic [7:0] OP_OUTER  = 8'h02;
  localparam logic [7:0] OP_STATE0 = 8'h03;
  localparam logic [7:0] OP_EDGE   = 8'h04;
  localparam logic [7:0] OP_COMMIT = 8'h05;
  localparam logic [7:0] OP_CLEAR  = 8'h06;

  localparam int COUNT_BITS_DEF = 32;
  localparam int CH_LOG2_DEF    = 3;
  localparam int ED_MAX_DEF     = 100;
  localparam int CH_MAX         = 1 << CH_LOG2_DEF;
  localparam int ED_BITS        = 2 * COUNT_BITS_DEF + CH_LOG2_DEF + 1;

  // Edge record, LSB first: toggle, ch_id, x, dx.
  localparam int ED_TOG_OFS = 0;
  localparam int ED_CH_OFS  = 1;

  function automatic int ed_x_ofs(input int ch_log2);
    return ch_log2 + 1;
  endfunction

  function automatic int ed_dx_ofs(input int count_bits, input int ch_log2);
    return ch_log2 + 1 + count_bits;
  endfunction

  function automatic int ed_bits(input int count_bits, input int ch_log2);
    return 2 * count_bits + ch_log2 + 1;
  endfunction

  typedef enum logic [1:0] {ST_IDLE, ST_PAYLOAD, ST_COMMIT, ST_RESTART} ld_state_e;
  typedef enum logic [1:0] {EP_IDX, EP_FLAG, EP_X, EP_DX} edge_phase_e;

endpackage

// File: rtl/le_byte_assembler.sv
// Little-endian word builder: load arms a byte count, each shift drops the
// next byte into place. word/last already include the byte being shifted.
module le_byte_assembler #(
  parameter int W  = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_cnt,
  input  logic          shift,
  input  logic [7:0]    in_byte,
  output logic [W-1:0]  word,
  output logic          last
);

  localparam int NB = W / 8;

  logic [W-1:0]  acc_q, acc_d;
  logic [CW-1:0] pos_q, pos_d;
  logic [CW-1:0] rem_q, rem_d;
  logic          take;

  assign take = shift && (rem_q != '0);
  assign last = shift && (rem_q == CW'(1));

  always_comb begin
    word = acc_q;
    if (take) begin
      for (int b = 0; b < NB; b++)
        if (pos_q == CW'(b)) word[b*8 +: 8] = in_byte;
    end
  end

  // A load on the same cycle as a final shift re-arms for the next field.
  always_comb begin
    acc_d = acc_q;
    pos_d = pos_q;
    rem_d = rem_q;
    if (load) begin
      acc_d = '0;
      pos_d = '0;
      rem_d = load_cnt;
    end else if (take) begin
      acc_d = word;
      pos_d = pos_q + CW'(1);
      rem_d = rem_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
      pos_q <= '0;
      rem_q <= '0;
    end else begin
      acc_q <= acc_d;
      pos_q <= pos_d;
      rem_q <= rem_d;
    end
  end

endmodule

// File: rtl/pulse_table_loader.sv
// Byte-stream configuration loader: builds a shadow pulse table and swaps it
// into the active bank atomically on COMMIT, then restarts the generator.
module pulse_table_loader
  import pulse_pkg::*;
#(
  parameter int COUNT_BITS = 32,
  parameter int CH_LOG2    = 3,
  parameter int ED_MAX     = 100,
  localparam int CHN       = 1 << CH_LOG2,
  localparam int EDB       = ed_bits(COUNT_BITS, CH_LOG2)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [COUNT_BITS-1:0] period,
  output logic [COUNT_BITS-1:0] outer_period,
  output logic [CHN-1:0]        state0,
  output logic [EDB*ED_MAX-1:0] eds,
  output logic                  core_reset,
  output logic                  busy,
  output logic                  err
);

  localparam int NB_CNT = COUNT_BITS / 8;
  localparam int NB_ST  = CHN / 8;
  localparam int AW     = (COUNT_BITS > CHN) ? COUNT_BITS : CHN;
  localparam int CW     = 16;

  ld_state_e   state_q, state_d;
  edge_phase_e phase_q, phase_d;
  logic [7:0]  op_q, op_d;
  logic [7:0]  idx_q, idx_d;
  logic [CH_LOG2:0]      flag_q, flag_d;
  logic [COUNT_BITS-1:0] x_q, x_d;
  logic        rcnt_q, rcnt_d;
  logic        err_q, err_d;
  logic        boot_q, boot_d;

  logic [COUNT_BITS-1:0] sh_period_q, sh_period_d, act_period_q, act_period_d;
  logic [COUNT_BITS-1:0] sh_outer_q, sh_outer_d, act_outer_q, act_outer_d;
  logic [CHN-1:0]        sh_state0_q, sh_state0_d, act_state0_q, act_state0_d;
  logic [ED_MAX-1:0][EDB-1:0] sh_eds_q, sh_eds_d, act_eds_q, act_eds_d;

  logic          accept;
  logic          asm_load, asm_shift, asm_last;
  logic [CW-1:0] asm_cnt;
  logic [AW-1:0] asm_word;

  le_byte_assembler #(.W(AW), .CW(CW)) u_asm (
    .clk      (clk),
    .reset    (reset),
    .load     (asm_load),
    .load_cnt (asm_cnt),
    .shift    (asm_shift),
    .in_byte  (in_data),
    .word     (asm_word),
    .last     (asm_last)
  );

  assign in_ready     = (state_q == ST_IDLE) || (state_q == ST_PAYLOAD);
  assign accept       = in_valid && in_ready;
  assign busy         = (state_q != ST_IDLE);
  assign err          = err_q;
  assign core_reset   = boot_q || (state_q == ST_RESTART);
  assign period       = act_period_q;
  assign outer_period = act_outer_q;
  assign state0       = act_state0_q;
  assign eds          = act_eds_q;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    op_d         = op_q;
    idx_d        = idx_q;
    flag_d       = flag_q;
    x_d          = x_q;
    rcnt_d       = rcnt_q;
    err_d        = err_q;
    boot_d       = 1'b0;
    sh_period_d  = sh_period_q;
    sh_outer_d   = sh_outer_q;
    sh_state0_d  = sh_state0_q;
    sh_eds_d     = sh_eds_q;
    act_period_d = act_period_q;
    act_outer_d  = act_outer_q;
    act_state0_d = act_state0_q;
    act_eds_d    = act_eds_q;
    asm_load     = 1'b0;
    asm_cnt      = '0;
    asm_shift    = 1'b0;

    case (state_q)
      ST_IDLE: if (accept) begin
        case (in_data)
          OP_PERIOD, OP_OUTER: begin
            op_d     = in_data;
            asm_load = 1'b1;
            asm_cnt  = CW'(NB_CNT);
            state_d  = ST_PAYLOAD;
          end
          OP_STATE0: begin
            op_d     = in_data;
            asm_load = 1'b1;
            asm_cnt  = CW'(NB_ST);
            state_d  = ST_PAYLOAD;
          end
          OP_EDGE: begin
            op_d    = in_data;
            phase_d = EP_IDX;
            state_d = ST_PAYLOAD;
          end
          OP_COMMIT: state_d = ST_COMMIT;
          OP_CLEAR:  sh_eds_d = '0;
          default:   err_d = 1'b1;
        endcase
      end

      ST_PAYLOAD: if (accept) begin
        if (op_q == OP_EDGE) begin
          case (phase_q)
            EP_IDX: begin
              idx_d   = in_data;
              phase_d = EP_FLAG;
            end
            EP_FLAG: begin
              flag_d   = in_data[CH_LOG2:0];
              asm_load = 1'b1;
              asm_cnt  = CW'(NB_CNT);
              phase_d  = EP_X;
            end
            EP_X: begin
              asm_shift = 1'b1;
              if (asm_last) begin
                x_d      = asm_word[COUNT_BITS-1:0];
                asm_load = 1'b1;
                asm_cnt  = CW'(NB_CNT);
                phase_d  = EP_DX;
              end
            end
            default: begin
              asm_shift = 1'b1;
              if (asm_last) begin
                state_d = ST_IDLE;
                // Out-of-range slots still eat the whole payload.
                if (32'(idx_q) < ED_MAX) begin
                  for (int i = 0; i < ED_MAX; i++)
                    if (idx_q == 8'(i))
                      sh_eds_d[i] = {asm_word[COUNT_BITS-1:0], x_q, flag_q};
                end else begin
                  err_d = 1'b1;
                end
              end
            end
          endcase
        end else begin
          asm_shift = 1'b1;
          if (asm_last) begin
            state_d = ST_IDLE;
            case (op_q)
              OP_PERIOD: sh_period_d = asm_word[COUNT_BITS-1:0];
              OP_OUTER:  sh_outer_d  = asm_word[COUNT_BITS-1:0];
              default:   sh_state0_d = asm_word[CHN-1:0];
            endcase
          end
        end
      end

      ST_COMMIT: begin
        act_period_d = sh_period_q;
        act_outer_d  = sh_outer_q;
        act_state0_d = sh_state0_q;
        act_eds_d    = sh_eds_q;
        err_d        = 1'b0;
        rcnt_d       = 1'b0;
        state_d      = ST_RESTART;
      end

      default: begin
        if (rcnt_q) state_d = ST_IDLE;
        else        rcnt_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      phase_q      <= EP_IDX;
      op_q         <= '0;
      idx_q        <= '0;
      flag_q       <= '0;
      x_q          <= '0;
      rcnt_q       <= 1'b0;
      err_q        <= 1'b0;
      boot_q       <= 1'b1;
      sh_period_q  <= '0;
      sh_outer_q   <= '0;
      sh_state0_q  <= '0;
      sh_eds_q     <= '0;
      act_period_q <= '0;
      act_outer_q  <= '0;
      act_state0_q <= '0;
      act_eds_q    <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      op_q         <= op_d;
      idx_q        <= idx_d;
      flag_q       <= flag_d;
      x_q          <= x_d;
      rcnt_q       <= rcnt_d;
      err_q        <= err_d;
      boot_q       <= boot_d;
      sh_period_q  <= sh_period_d;
      sh_outer_q   <= sh_outer_d;
      sh_state0_q  <= sh_state0_d;
      sh_eds_q     <= sh_eds_d;
      act_period_q <= act_period_d;
      act_outer_q  <= act_outer_d;
      act_state0_q <= act_state0_d;
      act_eds_q    <= act_eds_d;
    end
  end

endmodule
